sprite_frame_ctrl: RTL and testbench

Frame-synchronous configuration controller for the VGA sprite renderer. It holds an Avalon-MM-writable shadow copy of every sprite position, the dino pose and the animation settings. At the start of vertical blank it commits the shadow copy to the active registers that the pixel datapath reads, so a sprite never tears mid-frame. It also keeps the run-animation phase, a frame counter and a vblank interrupt for the HPS software.

---
 rtl/sprite_ctrl_pkg.sv | 36 +++
 rtl/sprite_frame_ctrl_anim_timer.sv | 46 ++++
 rtl/sprite_frame_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_sprite_frame_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_ctrl_pkg.sv
// Shared types and register-map constants for the sprite frame controller.
// Holds the pose and FSM enums plus the frame-boundary decode helper.
package sprite_ctrl_pkg;

  localparam int X_W    = 11;
  localparam int Y_W    = 10;
  localparam int ADDR_W = 9;

  localparam logic [ADDR_W-1:0] ADDR_POSE   = 9'd16;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 9'd17;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 9'd18;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD = 9'd19;

  localparam logic [7:0] ANIM_PERIOD_RST = 8'd6;

  typedef enum logic [1:0] {
    POSE_RUN  = 2'd0,
    POSE_JUMP = 2'd1,
    POSE_DUCK = 2'd2,
    POSE_DEAD = 2'd3
  } pose_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // First pixel of the first blanked line: one cycle per frame.
  function automatic logic is_frame_boundary(input logic [X_W-1:0] h,
                                             input logic [Y_W-1:0] v,
                                             input logic [Y_W-1:0] vactive);
    return (h == '0) && (v == vactive);
  endfunction

endpackage

// File: rtl/sprite_frame_ctrl_anim_timer.sv
// Frame-counted animation divider: toggles run_phase every 'period' frame ticks.
// A period of zero parks the counter and freezes the phase.
module anim_timer
  import sprite_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] period,
  input  logic       period_wr,
  output logic       run_phase
);

  logic [7:0] counter_q, counter_d;
  logic       run_phase_q, run_phase_d;

  always_comb begin
    counter_d   = counter_q;
    run_phase_d = run_phase_q;
    if (period_wr) begin
      counter_d = '0;
    end else if (frame_tick) begin
      if (period == 8'd0) begin
        counter_d = '0;
      end else if (counter_q == period - 8'd1) begin
        counter_d   = '0;
        run_phase_d = ~run_phase_q;
      end else begin
        counter_d = counter_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q   <= '0;
      run_phase_q <= 1'b0;
    end else begin
      counter_q   <= counter_d;
      run_phase_q <= run_phase_d;
    end
  end

  assign run_phase = run_phase_q;

endmodule

// File: rtl/sprite_frame_ctrl.sv
// Shadow/active sprite configuration with vblank-synchronous commit, frame
// counter, animation phase and vblank interrupt behind an Avalon-MM slave.
module sprite_frame_ctrl
  import sprite_ctrl_pkg::*;
#(
  parameter int NUM_SPRITES = 6,
  parameter int VACTIVE     = 480
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       chipselect,
  input  logic                       write,
  input  logic                       read,
  input  logic [8:0]                 address,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  input  logic [10:0]                hcount,
  input  logic [9:0]                 vcount,
  output logic [NUM_SPRITES*11-1:0]  sprite_x,
  output logic [NUM_SPRITES*10-1:0]  sprite_y,
  output logic [1:0]                 pose,
  output logic                       run_phase,
  output logic [15:0]                frame_count,
  output logic                       commit_pulse,
  output logic                       vblank_irq
);

  localparam logic [Y_W-1:0]    VACTIVE_V = Y_W'(VACTIVE);
  localparam logic [ADDR_W-1:0] POS_END   = ADDR_W'(2 * NUM_SPRITES);

  logic wr_en, rd_en, boundary, commit, shadow_wr, pending, period_wr;

  logic [NUM_SPRITES*X_W-1:0] shadow_x_flat;
  logic [NUM_SPRITES*Y_W-1:0] shadow_y_flat;

  state_e      state_q, state_d;
  pose_e       shadow_pose_q, shadow_pose_d;
  pose_e       active_pose_q, active_pose_d;
  logic        commit_req_q, commit_req_d;
  logic        auto_commit_q, auto_commit_d;
  logic        dirty_q, dirty_d;
  logic        vblank_irq_q, vblank_irq_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [7:0]  anim_period_q, anim_period_d;
  logic [31:0] readdata_q, readdata_d;
  logic [31:0] rd_word;

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:X_W];

  assign wr_en     = chipselect & write;
  assign rd_en     = chipselect & read;
  assign boundary  = is_frame_boundary(hcount, vcount, VACTIVE_V);
  assign commit    = (state_q == COMMIT);
  assign shadow_wr = wr_en && ((address < POS_END) || (address == ADDR_POSE));
  assign pending   = commit_req_q | (auto_commit_q & dirty_q);
  assign period_wr = wr_en && (address == ADDR_PERIOD);

  // Per-sprite shadow/active pairs; the active copy only moves in COMMIT.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
      localparam logic [ADDR_W-1:0] ADDR_X = ADDR_W'(2 * gi);
      localparam logic [ADDR_W-1:0] ADDR_Y = ADDR_W'(2 * gi + 1);

      logic [X_W-1:0] shadow_x_q, shadow_x_d, active_x_q, active_x_d;
      logic [Y_W-1:0] shadow_y_q, shadow_y_d, active_y_q, active_y_d;

      always_comb begin
        shadow_x_d = shadow_x_q;
        shadow_y_d = shadow_y_q;
        active_x_d = active_x_q;
        active_y_d = active_y_q;
        if (wr_en && address == ADDR_X) shadow_x_d = writedata[X_W-1:0];
        if (wr_en && address == ADDR_Y) shadow_y_d = writedata[Y_W-1:0];
        if (commit) begin
          active_x_d = shadow_x_q;
          active_y_d = shadow_y_q;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          shadow_x_q <= '0;
          shadow_y_q <= '0;
          active_x_q <= '0;
          active_y_q <= '0;
        end else begin
          shadow_x_q <= shadow_x_d;
          shadow_y_q <= shadow_y_d;
          active_x_q <= active_x_d;
          active_y_q <= active_y_d;
        end
      end

      assign sprite_x[gi*X_W +: X_W]      = active_x_q;
      assign sprite_y[gi*Y_W +: Y_W]      = active_y_q;
      assign shadow_x_flat[gi*X_W +: X_W] = shadow_x_q;
      assign shadow_y_flat[gi*Y_W +: Y_W] = shadow_y_q;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending) state_d = ARMED;
      ARMED:   if (boundary) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A shadow write landing in the COMMIT cycle keeps dirty set so it ships next frame.
  always_comb begin
    shadow_pose_d = shadow_pose_q;
    active_pose_d = active_pose_q;
    commit_req_d  = commit_req_q;
    auto_commit_d = auto_commit_q;
    dirty_d       = dirty_q;
    anim_period_d = anim_period_q;
    if (commit) begin
      active_pose_d = shadow_pose_q;
      commit_req_d  = 1'b0;
      dirty_d       = 1'b0;
    end
    if (shadow_wr) dirty_d = 1'b1;
    if (wr_en && address == ADDR_POSE) shadow_pose_d = pose_e'(writedata[1:0]);
    if (wr_en && address == ADDR_CTRL) begin
      if (writedata[0]) commit_req_d = 1'b1;
      auto_commit_d = writedata[1];
    end
    if (period_wr) anim_period_d = writedata[7:0];
  end

  always_comb begin
    frame_count_d = frame_count_q;
    vblank_irq_d  = vblank_irq_q;
    if (boundary) frame_count_d = frame_count_q + 16'd1;
    if (wr_en && address == ADDR_STATUS) vblank_irq_d = 1'b0;
    if (boundary) vblank_irq_d = 1'b1;
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (address == ADDR_W'(2 * i))     rd_word = 32'(shadow_x_flat[i*X_W +: X_W]);
      if (address == ADDR_W'(2 * i + 1)) rd_word = 32'(shadow_y_flat[i*Y_W +: Y_W]);
    end
    if (address == ADDR_POSE)   rd_word = {30'd0, shadow_pose_q};
    if (address == ADDR_CTRL)   rd_word = {30'd0, auto_commit_q, commit_req_q};
    if (address == ADDR_STATUS) rd_word = {frame_count_q, 13'd0, run_phase, vblank_irq_q, pending};
    if (address == ADDR_PERIOD) rd_word = {24'd0, anim_period_q};
  end

  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) readdata_d = rd_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      shadow_pose_q <= POSE_RUN;
      active_pose_q <= POSE_RUN;
      commit_req_q  <= 1'b0;
      auto_commit_q <= 1'b1;
      dirty_q       <= 1'b0;
      vblank_irq_q  <= 1'b0;
      frame_count_q <= '0;
      anim_period_q <= ANIM_PERIOD_RST;
      readdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      shadow_pose_q <= shadow_pose_d;
      active_pose_q <= active_pose_d;
      commit_req_q  <= commit_req_d;
      auto_commit_q <= auto_commit_d;
      dirty_q       <= dirty_d;
      vblank_irq_q  <= vblank_irq_d;
      frame_count_q <= frame_count_d;
      anim_period_q <= anim_period_d;
      readdata_q    <= readdata_d;
    end
  end

  anim_timer u_anim_timer (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (boundary),
    .period     (anim_period_q),
    .period_wr  (period_wr),
    .run_phase  (run_phase)
  );

  assign readdata     = readdata_q;
  assign pose         = active_pose_q;
  assign frame_count  = frame_count_q;
  assign commit_pulse = commit;
  assign vblank_irq   = vblank_irq_q;

endmodule

// File: tb/tb_sprite_frame_ctrl.sv
// Directed bench for sprite_frame_ctrl: register-map vector table followed by
// hand-built frame-boundary sequences for commit, animation, irq and reset.
`timescale 1ns/1ps
module tb_sprite_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [8:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [10:0] hcount = 11'd1;
  logic [9:0]  vcount = 10'd0;
  logic [65:0] sprite_x;
  logic [59:0] sprite_y;
  logic [1:0]  pose;
  logic        run_phase;
  logic [15:0] frame_count;
  logic        commit_pulse, vblank_irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_wr;
    logic [8:0]  addr;
    logic [31:0] data;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  sprite_frame_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .chipselect   (chipselect),
    .write        (write),
    .read         (read),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .hcount       (hcount),
    .vcount       (vcount),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .pose         (pose),
    .run_phase    (run_phase),
    .frame_count  (frame_count),
    .commit_pulse (commit_pulse),
    .vblank_irq   (vblank_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    hcount = 11'd1; vcount = 10'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wr_reg(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd_reg(input logic [8:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  // Drives one boundary cycle; returns at the negedge just after that cycle's edge.
  task automatic tick();
    @(negedge clk);
    hcount = 11'd0; vcount = 10'd480;
    @(negedge clk);
    hcount = 11'd1; vcount = 10'd0;
  endtask

  logic [31:0] rd;
  logic        rp_exp [12];

  initial begin
    vecs[0]  = '{0, 9'd17,  32'h0000_0002};
    vecs[1]  = '{0, 9'd19,  32'h0000_0006};
    vecs[2]  = '{0, 9'd16,  32'h0000_0000};
    vecs[3]  = '{0, 9'd18,  32'h0000_0000};
    vecs[4]  = '{1, 9'd0,   32'h0000_012C};
    vecs[5]  = '{0, 9'd0,   32'h0000_012C};
    vecs[6]  = '{1, 9'd3,   32'hFFFF_FFFF};
    vecs[7]  = '{0, 9'd3,   32'h0000_03FF};
    vecs[8]  = '{1, 9'd10,  32'hFFFF_FFFF};
    vecs[9]  = '{0, 9'd10,  32'h0000_07FF};
    vecs[10] = '{1, 9'd16,  32'h0000_0007};
    vecs[11] = '{0, 9'd16,  32'h0000_0003};
    vecs[12] = '{1, 9'd12,  32'h0000_0055};
    vecs[13] = '{0, 9'd12,  32'h0000_0000};
    vecs[14] = '{1, 9'd500, 32'h0000_0001};
    vecs[15] = '{0, 9'd500, 32'h0000_0000};
    vecs[16] = '{0, 9'd18,  32'h0000_0001};
    vecs[17] = '{1, 9'd17,  32'h0000_0000};
    vecs[18] = '{0, 9'd17,  32'h0000_0000};
    vecs[19] = '{0, 9'd18,  32'h0000_0000};

    rp_exp = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};

    do_reset();
    chk("rst_sprite_x", 32'(|sprite_x), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_readdata", readdata, 32'd0);

    // Register map table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        wr_reg(vecs[i].addr, vecs[i].data);
      end else begin
        rd_reg(vecs[i].addr, rd);
        chk($sformatf("vec%0d_rd_a%0d", i, vecs[i].addr), rd, vecs[i].data);
      end
    end

    // Auto-commit of a single position write
    do_reset();
    wr_reg(9'd0, 32'd300);
    idle(2);
    chk("auto_pre_boundary_x", 32'(sprite_x[10:0]), 32'd0);
    tick();
    chk("auto_commit_pulse", 32'(commit_pulse), 32'd1);
    chk("auto_x_in_commit", 32'(sprite_x[10:0]), 32'd0);
    chk("frame_count_1", 32'(frame_count), 32'd1);
    chk("irq_set", 32'(vblank_irq), 32'd1);
    idle(1);
    chk("auto_x_after", 32'(sprite_x[10:0]), 32'd300);
    chk("auto_pulse_one_cycle", 32'(commit_pulse), 32'd0);

    // Manual commit with auto off
    wr_reg(9'd17, 32'd0);
    wr_reg(9'd1, 32'd200);
    for (int f = 0; f < 2; f++) begin
      idle(2);
      tick();
      chk($sformatf("manual_no_pulse_f%0d", f), 32'(commit_pulse), 32'd0);
    end
    idle(1);
    chk("manual_y_held", 32'(sprite_y[9:0]), 32'd0);
    rd_reg(9'd18, rd);
    chk("manual_not_pending", 32'(rd[0]), 32'd0);
    wr_reg(9'd17, 32'd1);
    rd_reg(9'd18, rd);
    chk("manual_pending", 32'(rd[0]), 32'd1);
    tick();
    idle(1);
    chk("manual_y_after", 32'(sprite_y[9:0]), 32'd200);
    rd_reg(9'd18, rd);
    chk("manual_status", rd, 32'h0004_0002);

    // Pending that rises in the boundary cycle waits for the next boundary
    wr_reg(9'd17, 32'd2);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = 9'd0; writedata = 32'd123;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; hcount = 11'd0; vcount = 10'd480;
    @(negedge clk);
    hcount = 11'd1; vcount = 10'd0;
    chk("late_pending_no_pulse", 32'(commit_pulse), 32'd0);
    idle(1);
    chk("late_pending_x_held", 32'(sprite_x[10:0]), 32'd300);
    tick();
    idle(1);
    chk("late_pending_x_after", 32'(sprite_x[10:0]), 32'd123);

    // Shadow write during the COMMIT cycle
    wr_reg(9'd2, 32'd40);
    idle(1);
    @(negedge clk);
    hcount = 11'd0; vcount = 10'd480;
    @(negedge clk);
    hcount = 11'd1; vcount = 10'd0;
    chk("cwr_pulse", 32'(commit_pulse), 32'd1);
    chipselect = 1'b1; write = 1'b1; address = 9'd2; writedata = 32'd50;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
    chk("cwr_x1_old", 32'(sprite_x[21:11]), 32'd40);
    rd_reg(9'd18, rd);
    chk("cwr_still_pending", 32'(rd[0]), 32'd1);
    idle(1);
    chk("cwr_x1_held", 32'(sprite_x[21:11]), 32'd40);
    tick();
    idle(1);
    chk("cwr_x1_next_frame", 32'(sprite_x[21:11]), 32'd50);

    // Animation phase: period 3, period rewrite, freeze, period 2
    do_reset();
    wr_reg(9'd19, 32'd3);
    for (int k = 0; k < 12; k++) begin
      if (k == 2) wr_reg(9'd19, 32'd3);
      if (k == 5) wr_reg(9'd19, 32'd0);
      if (k == 10) wr_reg(9'd19, 32'd2);
      tick();
      chk($sformatf("anim_tick%0d", k), 32'(run_phase), 32'(rp_exp[k]));
    end

    // vblank_irq clear racing a boundary
    @(negedge clk);
    hcount = 11'd0; vcount = 10'd480;
    chipselect = 1'b1; write = 1'b1; address = 9'd18; writedata = 32'd0;
    @(negedge clk);
    hcount = 11'd1; vcount = 10'd0; chipselect = 1'b0; write = 1'b0;
    chk("irq_set_wins", 32'(vblank_irq), 32'd1);
    idle(10);
    wr_reg(9'd18, 32'd0);
    chk("irq_cleared", 32'(vblank_irq), 32'd0);

    // frame_count wrap
    do_reset();
    @(negedge clk);
    hcount = 11'd0; vcount = 10'd480;
    repeat (65535) @(negedge clk);
    chk("fc_max", 32'(frame_count), 32'h0000_FFFF);
    @(negedge clk);
    hcount = 11'd1; vcount = 10'd0;
    chk("fc_wrap", 32'(frame_count), 32'd0);

    // Reset asserted during COMMIT
    do_reset();
    wr_reg(9'd0, 32'd77);
    tick();
    idle(1);
    chk("prerst_x", 32'(sprite_x[10:0]), 32'd77);
    wr_reg(9'd0, 32'd88);
    wr_reg(9'd16, 32'd3);
    rd_reg(9'd19, rd);
    idle(1);
    @(negedge clk);
    hcount = 11'd0; vcount = 10'd480;
    @(negedge clk);
    hcount = 11'd1; vcount = 10'd0;
    chk("prerst_pulse", 32'(commit_pulse), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_commit_x", 32'(|sprite_x), 32'd0);
    chk("rst_commit_y", 32'(|sprite_y), 32'd0);
    chk("rst_commit_pose", 32'(pose), 32'd0);
    chk("rst_commit_fc", 32'(frame_count), 32'd0);
    chk("rst_commit_irq", 32'(vblank_irq), 32'd0);
    chk("rst_commit_pulse", 32'(commit_pulse), 32'd0);
    chk("rst_commit_rp", 32'(run_phase), 32'd0);
    chk("rst_commit_rdata", readdata, 32'd0);
    rd_reg(9'd17, rd);
    chk("rst_ctrl", rd, 32'd2);
    rd_reg(9'd19, rd);
    chk("rst_period", rd, 32'd6);
    rd_reg(9'd0, rd);
    chk("rst_shadow_x", rd, 32'd0);
    tick();
    idle(1);
    chk("rst_no_commit", 32'(sprite_x[10:0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
